// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - registered ALU with iterative unsigned multiply/divide
// Single-cycle ops complete in IDLE; MULU/DIVU iterate WIDTH steps in ITER, then FIN writes results.
module multicycle_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [3:0]       AluCtrl,
  input  logic [WIDTH-1:0] DataIn1,
  input  logic [WIDTH-1:0] DataIn2,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] AluResult,
  output logic [WIDTH-1:0] AluResultHi,
  output logic             Zero,
  output logic             Overflow,
  output logic             DivByZero,
  output logic             IllegalOp
);

  localparam int CW = SHAMT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIN} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, r_b;
  logic [3:0]       r_op;
  logic             r_is_div, r_pend, r_done;
  logic [WIDTH-1:0] r_res, r_res_hi;
  logic             r_zero, r_ovf, r_dbz, r_ill;

  logic [3:0]         w_op;
  logic [WIDTH-1:0]   w_a, w_b, w_sum, w_diff, w_res, w_res_hi;
  logic [SHAMT_W-1:0] w_shamt;
  logic               w_ovf, w_dbz, w_ill, w_iter;
  logic [WIDTH:0]     w_mul_sum, w_div_sh;
  logic [WIDTH-1:0]   w_div_sub;
  logic               w_div_ge;

  // A single-cycle op accepted on the FIN edge is parked (r_pend) and executed from the operand registers next cycle.
  assign w_op    = r_pend ? r_op : AluCtrl;
  assign w_a     = r_pend ? r_lo : DataIn1;
  assign w_b     = r_pend ? r_b  : DataIn2;
  assign w_shamt = w_b[SHAMT_W-1:0];
  assign w_sum   = w_a + w_b;
  assign w_diff  = w_a - w_b;
  assign w_iter  = (w_op == 4'd11) || ((w_op == 4'd12) && (w_b != '0));

  always_comb begin
    w_res    = '0;
    w_res_hi = '0;
    w_ovf    = 1'b0;
    w_dbz    = 1'b0;
    w_ill    = 1'b0;
    case (w_op)
      4'd0: begin
        w_res = w_sum;
        w_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
      end
      4'd1: begin
        w_res = w_diff;
        w_ovf = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
      end
      4'd2:  w_res = w_a | w_b;
      4'd3:  w_res = w_a & w_b;
      4'd4:  w_res = w_a ^ w_b;
      4'd5:  w_res = ~(w_a | w_b);
      4'd6:  w_res = {{(WIDTH-1){1'b0}}, $signed(w_a) < $signed(w_b)};
      4'd7:  w_res = {{(WIDTH-1){1'b0}}, w_a < w_b};
      4'd8:  w_res = w_a << w_shamt;
      4'd9:  w_res = w_a >> w_shamt;
      4'd10: w_res = $signed(w_a) >>> w_shamt;
      4'd11: w_res = '0;
      4'd12: begin
        if (w_b == '0) begin
          w_res    = '1;
          w_res_hi = w_a;
          w_dbz    = 1'b1;
        end
      end
      4'd13: w_res = w_b;
      default: w_ill = 1'b1;
    endcase
  end

  // MULU: shift-add on {r_hi,r_lo}; DIVU: restoring divide, remainder in r_hi, quotient shifts into r_lo.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_div_sh  = {r_hi, r_lo[WIDTH-1]};
  assign w_div_ge  = w_div_sh >= {1'b0, r_b};
  assign w_div_sub = w_div_sh[WIDTH-1:0] - r_b;

  always_ff @(posedge Clk) begin
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (!r_pend && Start && w_iter) w_next = S_ITER;
      S_ITER:  if (r_cnt == CW'(1)) w_next = S_FIN;
      S_FIN:   w_next = (Start && w_iter) ? S_ITER : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    Busy = (r_state == S_ITER) || r_pend;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_is_div <= 1'b0;
      r_pend   <= 1'b0;
      r_done   <= 1'b0;
      r_res    <= '0;
      r_res_hi <= '0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_dbz    <= 1'b0;
      r_ill    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_pend || Start) begin
            r_pend <= 1'b0;
            if (w_iter) begin
              r_hi     <= '0;
              r_lo     <= w_a;
              r_b      <= w_b;
              r_is_div <= (w_op == 4'd12);
              r_cnt    <= CW'(WIDTH);
            end else begin
              r_res    <= w_res;
              r_res_hi <= w_res_hi;
              r_zero   <= (w_res == '0);
              r_ovf    <= w_ovf;
              r_dbz    <= w_dbz;
              r_ill    <= w_ill;
              r_done   <= 1'b1;
            end
          end
        end
        S_ITER: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_is_div) begin
            r_hi <= w_div_ge ? w_div_sub : w_div_sh[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], w_div_ge};
          end else begin
            r_hi <= w_mul_sum[WIDTH:1];
            r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
          end
        end
        S_FIN: begin
          r_res    <= r_lo;
          r_res_hi <= r_hi;
          r_zero   <= (r_lo == '0);
          r_ovf    <= 1'b0;
          r_dbz    <= 1'b0;
          r_ill    <= 1'b0;
          r_done   <= 1'b1;
          if (Start) begin
            r_hi  <= '0;
            r_lo  <= DataIn1;
            r_b   <= DataIn2;
            r_op  <= AluCtrl;
            r_cnt <= CW'(WIDTH);
            r_is_div <= (AluCtrl == 4'd12);
            r_pend   <= !w_iter;
          end
        end
        default: ;
      endcase
    end
  end

  assign Done        = r_done;
  assign AluResult   = r_res;
  assign AluResultHi = r_res_hi;
  assign Zero        = r_zero;
  assign Overflow    = r_ovf;
  assign DivByZero   = r_dbz;
  assign IllegalOp   = r_ill;

endmodule
